// File: rtl/cc_pipe_pkg.sv
// Shared types and constants for the CentralCore elastic pipeline registers.
package cc_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

    localparam int unsigned MEMWB_WIDTH = 139;

    // MEM/WB bundle {pad, rd, r, d, m2reg, wreg}, wreg in bit 0
    localparam int unsigned WREG_BIT  = 0;
    localparam int unsigned M2REG_BIT = 1;
    localparam int unsigned D_LSB     = 2;
    localparam int unsigned R_LSB     = 66;
    localparam int unsigned RD_LSB    = 130;

    typedef struct packed {
        logic [3:0]  pad;
        logic [4:0]  rd;
        logic [63:0] r;
        logic [63:0] d;
        logic        m2reg;
        logic        wreg;
    } memwb_t;

    function automatic logic [1:0] slot_count(input slot_state_e s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic stage: main + skid register pair with registered ready.
module pipe_skid_slot
    import cc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH          = MEMWB_WIDTH,
    parameter bit          CLEAR_ON_FLUSH = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    slot_state_e      state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             acc, pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign count     = slot_count(state);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        acc       = in_valid & in_ready;
        pop       = out_ready & out_valid;

        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    main_nxt  = in_data;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_nxt = in_data;
                end else if (pop) begin
                    state_nxt = EMPTY;
                    if (CLEAR_ON_FLUSH) main_nxt = '0;
                end else if (acc) begin
                    state_nxt = FULL;
                    skid_nxt  = in_data;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        // Flush overrides everything; a word accepted this edge is dropped.
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = CLEAR_ON_FLUSH ? '0 : main_q;
            skid_nxt  = CLEAR_ON_FLUSH ? '0 : skid_q;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Chain of STAGES elastic skid slots with flush and total occupancy count.
module pipe_stage_elastic
    import cc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH          = MEMWB_WIDTH,
    parameter int unsigned STAGES         = 1,
    parameter bit          CLEAR_ON_FLUSH = 1'b0
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    input  logic                              flush,
    output logic [$clog2(2*STAGES+1)-1:0]     occupancy
);

    localparam int unsigned OCC_W = $clog2(2*STAGES+1);

    logic             vld [STAGES+1];
    logic             rdy [STAGES+1];
    logic [WIDTH-1:0] dat [STAGES+1];
    logic [1:0]       cnt [STAGES];
    logic [OCC_W-1:0] occ_sum;

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign in_ready    = rdy[0];
    assign out_valid   = vld[STAGES];
    assign out_data    = dat[STAGES];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pipe_skid_slot #(
            .WIDTH          (WIDTH),
            .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
        ) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .flush     (flush),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_data   (dat[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k+1]),
            .count     (cnt[k])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occ_sum = occ_sum + OCC_W'(cnt[k]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed + scoreboard bench for pipe_stage_elastic on three configurations.
module tb_pipe_stage_elastic;
    import cc_pipe_pkg::*;

    localparam int unsigned W = MEMWB_WIDTH;
    typedef logic [W-1:0] word_t;

    logic  clk = 1'b0;
    logic  rstn;
    logic  iv [3];
    logic  ordy [3];
    logic  fl [3];
    word_t id [3];
    logic  ir [3];
    logic  ov [3];
    word_t od [3];
    logic [1:0] occ0;
    logic [2:0] occ1, occ2;

    always #5 clk = ~clk;

    // dut0: STAGES=1 clear, dut1: STAGES=2 stale, dut2: STAGES=3 clear
    pipe_stage_elastic #(.WIDTH(W), .STAGES(1), .CLEAR_ON_FLUSH(1'b1)) u_dut0 (
        .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .flush(fl[0]), .occupancy(occ0));
    pipe_stage_elastic #(.WIDTH(W), .STAGES(2), .CLEAR_ON_FLUSH(1'b0)) u_dut1 (
        .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .flush(fl[1]), .occupancy(occ1));
    pipe_stage_elastic #(.WIDTH(W), .STAGES(3), .CLEAR_ON_FLUSH(1'b1)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .flush(fl[2]), .occupancy(occ2));

    int    checks = 0;
    int    errors = 0;
    int    occ_m [3];
    int    pops [3];
    word_t q0 [$];
    word_t q1 [$];
    word_t q2 [$];

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int occ_of(input int i);
        case (i)
            0:       return int'(occ0);
            1:       return int'(occ1);
            default: return int'(occ2);
        endcase
    endfunction

    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic sb_push(input int i, input word_t w);
        case (i)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic sb_pop(input int i, output word_t w, output bit ok);
        w  = '0;
        ok = 1'b0;
        if (sb_size(i) > 0) begin
            ok = 1'b1;
            case (i)
                0:       w = q0.pop_front();
                1:       w = q1.pop_front();
                default: w = q2.pop_front();
            endcase
        end
    endtask

    task automatic sb_clear(input int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
            fl[i]   = 1'b0;
            id[i]   = '0;
        end
    endtask

    // One clock edge; scoreboard and occupancy model follow the handshakes.
    task automatic cyc();
        logic  a_ [3];
        logic  p_ [3];
        logic  f_ [3];
        word_t d_ [3];
        word_t in_ [3];
        logic  rs;
        word_t w;
        bit    ok;
        rs = rstn;
        for (int i = 0; i < 3; i++) begin
            a_[i]  = iv[i] & ir[i];
            p_[i]  = ov[i] & ordy[i];
            f_[i]  = fl[i];
            d_[i]  = od[i];
            in_[i] = id[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rs && p_[i]) begin
                pops[i]++;
                sb_pop(i, w, ok);
                if (ok) check("order", 160'(d_[i]), 160'(w));
                else    check("order_extra", 160'(p_[i]), 160'(0));
            end
            if (!rs || f_[i]) begin
                sb_clear(i);
                occ_m[i] = 0;
            end else begin
                if (a_[i]) sb_push(i, in_[i]);
                occ_m[i] = occ_m[i] + int'(a_[i]) - int'(p_[i]);
            end
            check("occ", 160'(occ_of(i)), 160'(occ_m[i]));
        end
    endtask

    task automatic check_reset_state(input int i);
        check("rst_valid", 160'(ov[i]), 160'(0));
        check("rst_data", 160'(od[i]), 160'(0));
        check("rst_occ", 160'(occ_of(i)), 160'(0));
        check("rst_ready", 160'(ir[i]), 160'(1));
    endtask

    initial begin
        int    first;
        int    nacc;
        int    seen;
        logic  hold [3];
        word_t one_word;

        for (int i = 0; i < 3; i++) begin
            occ_m[i] = 0;
            pops[i]  = 0;
        end
        idle_all();
        rstn = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) check_reset_state(i);
        rstn = 1'b1;
        cyc();

        // single word through the one-stage chain
        one_word = 139'h1_0000_0000_0000_0001;
        iv[0] = 1'b1; id[0] = one_word; ordy[0] = 1'b1;
        cyc();
        iv[0] = 1'b0;
        check("single_valid", 160'(ov[0]), 160'(1));
        check("single_data", 160'(od[0]), 160'(one_word));
        check("single_occ", 160'(occ0), 160'(1));
        cyc();
        check("single_gone", 160'(ov[0]), 160'(0));
        check("single_clr", 160'(od[0]), 160'(0));
        idle_all();

        // streaming 0..99 through three stages
        ordy[2] = 1'b1;
        pops[2] = 0;
        first   = -1;
        for (int e = 1; e <= 103; e++) begin
            if (e <= 100) begin
                iv[2] = 1'b1;
                id[2] = W'(e - 1);
                check("stream_ready", 160'(ir[2]), 160'(1));
            end else begin
                iv[2] = 1'b0;
            end
            cyc();
            if (first < 0 && ov[2]) first = e;
        end
        check("stream_lat", 160'(first), 160'(3));
        check("stream_count", 160'(pops[2]), 160'(100));
        check("stream_empty", 160'(ov[2]), 160'(0));
        idle_all();

        // back-pressure fill, then release
        nacc    = 0;
        pops[1] = 0;
        for (int c = 0; c < 8; c++) begin
            iv[1] = 1'b1;
            id[1] = W'(nacc);
            if (ir[1]) nacc++;
            cyc();
        end
        check("bp_accepts", 160'(nacc), 160'(4));
        check("bp_ready", 160'(ir[1]), 160'(0));
        check("bp_occ", 160'(occ1), 160'(4));
        ordy[1] = 1'b1;
        id[1]   = W'(nacc);
        cyc();
        check("bp_ready_lag", 160'(ir[1]), 160'(0));
        cyc();
        check("bp_ready_back", 160'(ir[1]), 160'(1));
        for (int c = 0; c < 20; c++) begin
            check("bp_nogap", 160'(ov[1]), 160'(1));
            id[1] = W'(nacc);
            if (ir[1]) nacc++;
            cyc();
        end
        iv[1] = 1'b0;
        for (int c = 0; c < 6; c++) cyc();
        check("bp_drain", 160'(pops[1]), 160'(nacc));
        check("bp_occ_end", 160'(occ1), 160'(0));
        idle_all();

        // flush with three words held, one word offered on the flush edge
        for (int c = 0; c < 3; c++) begin
            for (int i = 1; i < 3; i++) begin
                iv[i] = 1'b1;
                id[i] = W'(8'h11 * (c + 1));
            end
            cyc();
        end
        check("fl_occ1", 160'(occ1), 160'(3));
        check("fl_occ2", 160'(occ2), 160'(3));
        for (int i = 1; i < 3; i++) begin
            fl[i] = 1'b1;
            id[i] = W'(8'hAA);
        end
        cyc();
        for (int i = 1; i < 3; i++) begin
            fl[i] = 1'b0;
            iv[i] = 1'b0;
            check("fl_valid", 160'(ov[i]), 160'(0));
            check("fl_occ", 160'(occ_of(i)), 160'(0));
            check("fl_ready", 160'(ir[i]), 160'(1));
        end
        check("fl_stale", 160'(od[1]), 160'(8'h11));
        check("fl_clear", 160'(od[2]), 160'(0));
        seen = 0;
        ordy[1] = 1'b1;
        ordy[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (ov[1] || ov[2]) seen++;
        end
        check("fl_no_aa", 160'(seen), 160'(0));
        idle_all();

        // reset together with flush, word offered mid-reset
        iv[1] = 1'b1; id[1] = W'(8'h55);
        cyc();
        id[1] = W'(8'h66);
        cyc();
        check("rf_occ", 160'(occ1), 160'(2));
        rstn  = 1'b0;
        fl[1] = 1'b1;
        id[1] = W'(8'h77);
        cyc();
        rstn  = 1'b1;
        iv[1] = 1'b0;
        check_reset_state(1);
        cyc();
        fl[1] = 1'b0;
        check_reset_state(1);
        idle_all();

        // random traffic with protocol-correct hold of unaccepted words
        for (int i = 0; i < 3; i++) hold[i] = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!hold[i]) begin
                    iv[i] = 1'($urandom_range(0, 1));
                    id[i] = W'({$urandom, $urandom, $urandom, $urandom, $urandom});
                end
                ordy[i] = 1'($urandom_range(0, 1));
                fl[i]   = ($urandom_range(0, 255) == 0);
                hold[i] = iv[i] & ~ir[i];
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
        end
        for (int c = 0; c < 12; c++) cyc();
        for (int i = 0; i < 3; i++) begin
            check("rand_sb_empty", 160'(sb_size(i)), 160'(0));
            check("rand_occ_end", 160'(occ_of(i)), 160'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
